// File: rtl/dmem_lane_arbiter.sv
// Dual-lane load/store scheduler for a dual-read / single-write data memory.
// Same-cycle store pairs are serialized through a one-entry pending buffer.
module dmem_lane_arbiter #(
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vld0_i,
    input  logic          vld1_i,
    input  logic          st0_i,
    input  logic          st1_i,
    input  logic [2:0]    f3_0_i,
    input  logic [2:0]    f3_1_i,
    input  logic [31:0]   addr0_i,
    input  logic [31:0]   addr1_i,
    input  logic [31:0]   wdat0_i,
    input  logic [31:0]   wdat1_i,
    output logic          ready_o,
    output logic [3:0]    mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [AW-1:0] mem_raddr1_o,
    output logic [AW-1:0] mem_raddr2_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata1_i,
    input  logic [31:0]   mem_rdata2_i,
    output logic          ld_vld0_o,
    output logic          ld_vld1_o,
    output logic [31:0]   ld_dat0_o,
    output logic [31:0]   ld_dat1_o,
    output logic          err0_o,
    output logic          err1_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic logic op_legal(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic f3_ok;
        logic al_ok;
        if (st) begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end
        case (f3[1:0])
            2'b01:   al_ok = ~off[0];
            2'b10:   al_ok = (off == 2'b00);
            default: al_ok = 1'b1;
        endcase
        return f3_ok & al_ok;
    endfunction

    function automatic logic [3:0] st_we(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] we;
        case (f3[1:0])
            2'b00:   we = 4'b0001 << off;
            2'b01:   we = off[1] ? 4'b1100 : 4'b0011;
            default: we = 4'b1111;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] wdat);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wdat[7:0]}};
            2'b01:   d = {2{wdat[15:0]}};
            default: d = wdat;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      pend_we_q, pend_we_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [31:0]     pend_data_q, pend_data_d;
    logic [3:0]      fwd_we_q, fwd_we_d;
    logic [31:0]     fwd_data_q;
    logic            ld0_vld_q, ld1_vld_q;
    logic [2:0]      ld0_f3_q, ld1_f3_q;
    logic [1:0]      ld0_off_q, ld1_off_q;
    logic            err0_q, err1_q;

    logic            acc0_s, acc1_s, ok0_s, ok1_s;
    logic            sst0_s, sst1_s, sld0_s, sld1_s, pair_s;
    logic [3:0]      we_s;
    logic [AW-1:0]   waddr_s;
    logic [31:0]     wdata_s;
    logic [31:0]     rdata2_merged_s;
    logic            unused_s;

    assign ready_o      = (state_q == IDLE);
    assign acc0_s       = vld0_i & ready_o;
    assign acc1_s       = vld1_i & ready_o;
    assign ok0_s        = acc0_s & op_legal(st0_i, f3_0_i, addr0_i[1:0]);
    assign ok1_s        = acc1_s & op_legal(st1_i, f3_1_i, addr1_i[1:0]);
    assign sst0_s       = ok0_s & st0_i;
    assign sst1_s       = ok1_s & st1_i;
    assign sld0_s       = ok0_s & ~st0_i;
    assign sld1_s       = ok1_s & ~st1_i;
    assign pair_s       = sst0_s & sst1_s;
    assign mem_raddr1_o = addr0_i[AW+1:2];
    assign mem_raddr2_o = addr1_i[AW+1:2];
    assign unused_s     = ^{addr0_i[31:AW+2], addr1_i[31:AW+2]};

    // Next state and write-port selection: pending store owns the port in DRAIN.
    always_comb begin
        state_d = state_q;
        we_s    = 4'b0000;
        waddr_s = '0;
        wdata_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (sst0_s) begin
                    we_s    = st_we(f3_0_i, addr0_i[1:0]);
                    waddr_s = addr0_i[AW+1:2];
                    wdata_s = st_data(f3_0_i, wdat0_i);
                end else if (sst1_s) begin
                    we_s    = st_we(f3_1_i, addr1_i[1:0]);
                    waddr_s = addr1_i[AW+1:2];
                    wdata_s = st_data(f3_1_i, wdat1_i);
                end else begin
                    we_s    = 4'b0000;
                end
                state_d = pair_s ? DRAIN : IDLE;
            end
            DRAIN: begin
                we_s    = pend_we_q;
                waddr_s = pend_addr_q;
                wdata_s = pend_data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we_o    = rst_ni ? we_s : 4'b0000;
    assign mem_waddr_o = waddr_s;
    assign mem_wdata_o = wdata_s;

    // Pending-buffer and forwarding capture.
    always_comb begin
        pend_we_d   = 4'b0000;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        fwd_we_d    = 4'b0000;
        if (pair_s) begin
            pend_we_d   = st_we(f3_1_i, addr1_i[1:0]);
            pend_addr_d = addr1_i[AW+1:2];
            pend_data_d = st_data(f3_1_i, wdat1_i);
        end else begin
            pend_we_d   = 4'b0000;
        end
        // Older lane-0 store into the same word a lane-1 load is reading
        if (sst0_s && sld1_s && (addr0_i[AW+1:2] == addr1_i[AW+1:2])) begin
            fwd_we_d = st_we(f3_0_i, addr0_i[1:0]);
        end else begin
            fwd_we_d = 4'b0000;
        end
    end

    // State, pending, forwarding and load-metadata registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pend_we_q   <= 4'b0000;
            pend_addr_q <= '0;
            pend_data_q <= 32'h0000_0000;
            fwd_we_q    <= 4'b0000;
            fwd_data_q  <= 32'h0000_0000;
            ld0_vld_q   <= 1'b0;
            ld1_vld_q   <= 1'b0;
            ld0_f3_q    <= 3'b000;
            ld1_f3_q    <= 3'b000;
            ld0_off_q   <= 2'b00;
            ld1_off_q   <= 2'b00;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            fwd_we_q    <= fwd_we_d;
            fwd_data_q  <= st_data(f3_0_i, wdat0_i);
            ld0_vld_q   <= sld0_s;
            ld1_vld_q   <= sld1_s;
            ld0_f3_q    <= f3_0_i;
            ld1_f3_q    <= f3_1_i;
            ld0_off_q   <= addr0_i[1:0];
            ld1_off_q   <= addr1_i[1:0];
            err0_q      <= acc0_s & ~ok0_s;
            err1_q      <= acc1_s & ~ok1_s;
        end
    end

    // Overlay forwarded store bytes on read port 2.
    always_comb begin
        rdata2_merged_s = mem_rdata2_i;
        for (int b = 0; b < 4; b++) begin
            if (fwd_we_q[b]) begin
                rdata2_merged_s[8*b +: 8] = fwd_data_q[8*b +: 8];
            end else begin
                rdata2_merged_s[8*b +: 8] = mem_rdata2_i[8*b +: 8];
            end
        end
    end

    assign ld_vld0_o = ld0_vld_q;
    assign ld_vld1_o = ld1_vld_q;
    assign ld_dat0_o = ld_extract(mem_rdata1_i, ld0_f3_q, ld0_off_q);
    assign ld_dat1_o = ld_extract(rdata2_merged_s, ld1_f3_q, ld1_off_q);
    assign err0_o    = err0_q;
    assign err1_o    = err1_q;

endmodule

// File: doc/dmem_lane_arbiter.md
# dmem_lane_arbiter

Load/store scheduler for the superscalar core's dual-read / single-write data memory. It accepts up to two memory operations per cycle from the two execute lanes, generates word addresses, byte enables and replicated store data for the memory, and serializes same-cycle store pairs through a one-entry pending buffer. It aligns and sign-extends load results, and forwards lane-0 store bytes into a same-cycle lane-1 load of the same word.

## Interface
- AW, 15: word-address width of the data memory; word address = byte address [AW+1:2].
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- vld0, vld1  in  1  lane operation valid.
- st0, st1  in  1  1 = store, 0 = load.
- f3_0, f3_1  in  3  RV32I funct3 (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw).
- addr0, addr1  in  32  byte address.
- wdat0, wdat1  in  32  store data, unaligned (value in low bits).
- ready  out  1  both lanes accepted this cycle when 1; upstream holds inputs while 0.
- mem_we  out  4  byte write enables to memory.
- mem_waddr, mem_raddr1, mem_raddr2  out  AW  memory write / read-port-1 (lane 0) / read-port-2 (lane 1) addresses.
- mem_wdata  out  32  byte-replicated store data.
- mem_rdata1, mem_rdata2  in  32  memory read data, registered, valid one cycle after address.
- ld_vld0, ld_vld1  out  1  load result valid.
- ld_dat0, ld_dat1  out  32  aligned, extended load result.
- err0, err1  out  1  one-cycle pulse: misaligned access or illegal funct3.

## Operation
- States: IDLE, DRAIN. Reset -> IDLE.
- IDLE: ready = 1. An operation is accepted when vldN & ready. Illegal ops (misaligned: h with addr[0]=1, w with addr[1:0]≠0; funct3 outside the lists above) are suppressed (no write, no ld_vld) and raise errN the next cycle.
- Store encoding: sb -> mem_we = 0001 << addr[1:0], data = {4{wdat[7:0]}}; sh -> mem_we = 0011 (addr[1]=0) or 1100, data = {2{wdat[15:0]}}; sw -> 1111, wdat.
- One store accepted: drive the write port this cycle.
- Two stores accepted (IDLE only): lane 0 written this cycle; lane 1 latched in the pending buffer (waddr, we, data); next state DRAIN.
- DRAIN: ready = 0; pending store driven on the write port; no reads; -> IDLE.
- Loads: mem_raddr1 = addr0 word, mem_raddr2 = addr1 word, combinational from inputs. Metadata (valid, f3, addr[1:0]) is registered and applied to mem_rdataN next cycle: byte/half selected by offset, sign-extended (lb/lh) or zero-extended (lbu/lhu).
- Forwarding: lane-0 store and lane-1 load accepted together, same word address -> register store bytes/enables; next cycle, merge bytes with mem_we set over mem_rdata2 before extraction. Lane-0 load with lane-1 store (load older) uses memory data unmodified. Two loads, any addresses: both served in parallel.
- mem_we = 0000 whenever no write is scheduled, and while rst_n = 0.
- Reset mid-DRAIN: pending store discarded, never written.

## Timing
- Load latency: accept at edge N -> ld_vldN/ld_datN valid during cycle N+1 (combinational from mem_rdata plus registered metadata); ld_vld is high for exactly one cycle.
- Store: write commits at the edge ending the accept cycle (lane 1 of a pair: one cycle later).
- ready deasserts for exactly one cycle per store pair; it is combinational from state only (never from inputs).
- A load accepted the cycle after a store to the same word reads new data through memory; no forwarding is needed.
- Reset values: state IDLE, ld_vld0/1 = 0, err0/1 = 0, pending and forwarding registers cleared, ready = 1 after release.

## Test plan
- Store then load: sw 0xDEADBEEF @0x100 (lane 0), next cycle lb @0x103 on lane 1 -> mem_we=1111, mem_waddr=0x40; ld_dat1=0xFFFFFFDE one cycle later.
- Store pair: sh 0x1234 @0x8 lane 0, sb 0xAB @0x9 lane 1 -> cycle N mem_we=0011 waddr=0x2; ready=0 in N+1 with mem_we=0010, data=0xABABABAB; lw @0x8 returns 0x0000AB34.
- Forwarding: word 0x10 holds 0x11223344; same cycle lane 0 sb 0x99 @0x41, lane 1 lw @0x40 -> ld_dat1=0x11229944.
- Misalign: lw @0x6 lane 0 -> no ld_vld0, err0 pulses next cycle, mem_we=0000.
- Dual load: lhu @0x2 and lh @0x2 with word 0x80010000 -> ld_dat0=0x00008001, ld_dat1=0xFFFF8001 same cycle.
- Reset during DRAIN: rst_n low in DRAIN cycle -> mem_we=0000, pending word unchanged in memory, ready=1 after release.
